gs_line_feeder: RTL and testbench
=================================

# gs_line_feeder

Ping-pong line-buffer feeder for the 5-tap Gaussian filter datapath. Accepts a pixel stream with valid/ready, writes alternate lines of `LINE_LEN` samples into two internal banks, and replays each completed line to the filter on per-bank valid/data pairs. It issues the filter's `start` clear pulse before every line and enforces a drain gap so the filter pipeline empties between lines.

## Interface
- `LINE_LEN`, 256: samples per line/bank; ≥ 2.
- `AW`, 8: bank address width; 2^AW ≥ LINE_LEN.
- `DRAIN_CYC`, 6: idle cycles after a line readout; ≥ 6, covering the filter's 5-cycle valid latency plus one.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  upstream sample valid.
- `in_data`  in  8  upstream sample.
- `in_ready`  out  1  sample accepted when `in_valid && in_ready`.
- `start`  out  1  one-cycle pulse to the filter before each line readout.
- `ram0_valid_out`  out  1  bank-0 sample valid to filter.
- `ram0_data_out`  out  8  bank-0 sample.
- `ram1_valid_out`  out  1  bank-1 sample valid to filter.
- `ram1_data_out`  out  8  bank-1 sample.
- `busy`  out  1  read FSM not in IDLE.

## Operation
- Storage: two banks of LINE_LEN × 8 bits, one write port and one synchronous read port each. Per-bank `full` flag.
- Write side: `wr_bank` (reset 0) and `wr_addr` (reset 0). `in_ready = !full[wr_bank]`, combinational. On accept, write `in_data` to `wr_bank[wr_addr]`.
  - At `wr_addr == LINE_LEN-1`: set `full[wr_bank]`, clear `wr_addr`, toggle `wr_bank`.
  - Otherwise increment `wr_addr`.
- Read FSM: `rd_bank` (reset 0), `rd_addr`, `drain_cnt`. States:
  - IDLE: if `full[rd_bank]`, go to START.
  - START: `start=1` for one cycle. Clear `rd_addr`. Go to READ.
  - READ: issue a read of `rd_bank[rd_addr]` and increment `rd_addr`. After the read at LINE_LEN-1, go to DRAIN with `drain_cnt=0`.
  - DRAIN: increment `drain_cnt`. At `drain_cnt == DRAIN_CYC-1`, clear `full[rd_bank]`, toggle `rd_bank`, and go to IDLE.
- Output stage: registered. The valid for bank b is asserted one cycle after the read is issued, and only on the `ram<b>` port.
  - The other port's valid and data are held at 0.
  - Both valids are never high in the same cycle; the filter XORs them.
- Simultaneous events:
  - A write completing bank X and a read release of bank Y (Y≠X) in the same cycle: both flag updates apply.
  - Release of the bank `wr_bank` points at makes `in_ready` rise on the next cycle.
- Both banks full: `in_ready=0` until the DRAIN release. Upstream stalls, and no data is lost or overwritten.
- Reset mid-operation: FSM goes to IDLE; pointers and flags clear; bank contents are not cleared; partially written lines are discarded.

## Timing
- Reset values:
  - `start`, all valids, all data: 0.
  - `busy`: 0.
  - `in_ready`: 1 from the first cycle after reset release.
- Fill-to-start: the cycle after the last sample of a line is accepted, `full` is visible and the FSM enters START. `start` is high the following cycle, if the FSM was in IDLE.
- Readout timing, with `start` high at cycle T:
  - Reads are issued T+1 … T+LINE_LEN.
  - `ram<b>_valid_out` is high T+2 … T+LINE_LEN+1, contiguous, with sample k at T+2+k.
- Period: one line occupies 1 + LINE_LEN + DRAIN_CYC cycles, plus one IDLE cycle before the next START. Sustained throughput requires an upstream average rate ≤ LINE_LEN / (LINE_LEN + DRAIN_CYC + 2).
- `busy` is high from START through the last DRAIN cycle.

## Configuration
- `GS_FEED_LINE_CNT_EN`:
  - Defined: adds output `line_cnt` [15:0], reset 0. It increments by 1 on each DRAIN release and wraps 0xFFFF→0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
All scenarios use LINE_LEN=8, DRAIN_CYC=6.
- Reset, then one line 0x10..0x17 at full rate:
  - `start` pulses once.
  - `ram0_valid_out` is high 8 consecutive cycles carrying 0x10..0x17, starting 2 cycles after `start`.
  - `ram1_valid_out` stays 0.
- Two back-to-back lines (0x00..0x07, 0x80..0x87):
  - The second line appears only on `ram1_*`, after a 6-cycle drain plus 1 IDLE cycle.
  - `start` pulses exactly twice.
  - The valids are never simultaneously high.
- Three lines offered at full rate, with no upstream readout delay:
  - `in_ready` drops after the 16th accepted sample and rises again the cycle after bank 0 is released.
  - The third line replays intact on `ram0_*`.
- `in_valid` toggling every other cycle within a line: the replayed line is contiguous (8 consecutive valid cycles) with the correct order.
- `rst_n=0` asserted for 1 cycle during READ of line 0:
  - The next cycle, all outputs are 0, `busy=0`, `in_ready=1`.
  - A subsequent full line replays from bank 0.
- With `GS_FEED_LINE_CNT_EN`: after 3 lines `line_cnt == 3`; forcing 0xFFFF then completing one line gives 0.

Source files
------------

// File: rtl/gs_line_feeder.sv
// Ping-pong line-buffer feeder for the 5-tap Gaussian filter: fills two banks alternately and replays each full line.
// Optional macro GS_FEED_LINE_CNT_EN adds a 16-bit wrapping count of released lines on output line_cnt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for the bank rd_bank points at to become full
// S_START | one-cycle start pulse to clear the filter, rd_addr cleared
// S_READ  | one synchronous read per cycle, addresses 0 .. LINE_LEN-1
// S_DRAIN | DRAIN_CYC idle cycles so the filter pipeline empties
module gs_line_feeder #(
    parameter int LINE_LEN  = 256,
    parameter int AW        = 8,
    parameter int DRAIN_CYC = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       start,
    output logic       ram0_valid_out,
    output logic [7:0] ram0_data_out,
    output logic       ram1_valid_out,
    output logic [7:0] ram1_data_out,
    output logic       busy
`ifdef GS_FEED_LINE_CNT_EN
    ,
    output logic [15:0] line_cnt
`endif
);

    localparam int DW = $clog2(DRAIN_CYC);
    localparam logic [AW-1:0] LAST_ADDR = AW'(LINE_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_READ, S_DRAIN} state_t;

    state_t          state_q, state_d;
    logic            wr_bank_q, wr_bank_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [1:0]      full_q, full_d;
    logic            rd_bank_q, rd_bank_d;
    logic [AW-1:0]   rd_addr_q, rd_addr_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            r0_valid_q, r0_valid_d;
    logic [7:0]      r0_data_q, r0_data_d;
    logic            r1_valid_q, r1_valid_d;
    logic [7:0]      r1_data_q, r1_data_d;
    logic            wr_fire;
    logic            rd_fire;
    logic            release_bank;

    logic [7:0] mem0 [LINE_LEN];
    logic [7:0] mem1 [LINE_LEN];

    assign in_ready       = !full_q[wr_bank_q];
    assign wr_fire        = in_valid && in_ready;
    assign start          = (state_q == S_START);
    assign busy           = (state_q != S_IDLE);
    assign ram0_valid_out = r0_valid_q;
    assign ram0_data_out  = r0_data_q;
    assign ram1_valid_out = r1_valid_q;
    assign ram1_data_out  = r1_data_q;

    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        full_d       = full_q;
        rd_bank_d    = rd_bank_q;
        rd_addr_d    = rd_addr_q;
        drain_d      = drain_q;
        rd_fire      = 1'b0;
        release_bank = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) state_d = S_START;
            end
            S_START: begin
                rd_addr_d = '0;
                state_d   = S_READ;
            end
            S_READ: begin
                rd_fire   = 1'b1;
                rd_addr_d = rd_addr_q + AW'(1);
                if (rd_addr_q == LAST_ADDR) begin
                    drain_d = DW'(DRAIN_CYC - 1);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drain_q == '0) begin
                    release_bank = 1'b1;
                    rd_bank_d    = !rd_bank_q;
                    state_d      = S_IDLE;
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A full bank never accepts writes, so release and fill always touch different banks.
        if (release_bank) full_d[rd_bank_q] = 1'b0;

        if (wr_fire) begin
            if (wr_addr_q == LAST_ADDR) begin
                full_d[wr_bank_q] = 1'b1;
                wr_addr_d         = '0;
                wr_bank_d         = !wr_bank_q;
            end else begin
                wr_addr_d = wr_addr_q + AW'(1);
            end
        end

        r0_valid_d = rd_fire && !rd_bank_q;
        r1_valid_d = rd_fire && rd_bank_q;
        r0_data_d  = r0_valid_d ? mem0[rd_addr_q] : 8'h00;
        r1_data_d  = r1_valid_d ? mem1[rd_addr_q] : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            full_q     <= '0;
            rd_bank_q  <= 1'b0;
            rd_addr_q  <= '0;
            drain_q    <= '0;
            r0_valid_q <= 1'b0;
            r0_data_q  <= 8'h00;
            r1_valid_q <= 1'b0;
            r1_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            full_q     <= full_d;
            rd_bank_q  <= rd_bank_d;
            rd_addr_q  <= rd_addr_d;
            drain_q    <= drain_d;
            r0_valid_q <= r0_valid_d;
            r0_data_q  <= r0_data_d;
            r1_valid_q <= r1_valid_d;
            r1_data_q  <= r1_data_d;
        end
    end

    // Bank contents survive reset; only the pointers and flags are cleared.
    always_ff @(posedge clk) begin
        if (rst_n && wr_fire) begin
            if (wr_bank_q) mem1[wr_addr_q] <= in_data;
            else           mem0[wr_addr_q] <= in_data;
        end
    end

`ifdef GS_FEED_LINE_CNT_EN
    logic [15:0] line_cnt_q, line_cnt_d;

    always_comb begin
        line_cnt_d = line_cnt_q;
        if (release_bank) line_cnt_d = line_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) line_cnt_q <= 16'h0000;
        else        line_cnt_q <= line_cnt_d;
    end

    assign line_cnt = line_cnt_q;
`endif

endmodule

// File: tb/tb_gs_line_feeder.sv
// Scoreboard bench for gs_line_feeder (LINE_LEN=8, DRAIN_CYC=6): accepted samples queue the expected
// bank/data pair, and a negedge monitor pops and compares every valid output beat, including its cycle.
module tb_gs_line_feeder;

    localparam int LL = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       start;
    logic       ram0_valid_out;
    logic [7:0] ram0_data_out;
    logic       ram1_valid_out;
    logic [7:0] ram1_data_out;
    logic       busy;
`ifdef GS_FEED_LINE_CNT_EN
    logic [15:0] line_cnt;
`endif

    gs_line_feeder #(.LINE_LEN(LL), .AW(3), .DRAIN_CYC(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .start          (start),
        .ram0_valid_out (ram0_valid_out),
        .ram0_data_out  (ram0_data_out),
        .ram1_valid_out (ram1_valid_out),
        .ram1_data_out  (ram1_data_out),
        .busy           (busy)
`ifdef GS_FEED_LINE_CNT_EN
        ,
        .line_cnt       (line_cnt)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [8:0] exp_q[$];
    int         start_cycs[$];
    int         start_cnt = 0;
    int         last_start = 0;
    int         beat_k = 0;
    logic       mdl_bank = 1'b0;
    int         mdl_cnt = 0;
    int         last_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected {bank,data} per valid beat and checks its cycle against the last start.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst_n === 1'b1) begin
            if (start) begin
                start_cnt++;
                start_cycs.push_back(cyc);
                last_start = cyc;
                beat_k     = 0;
            end
            if (ram0_valid_out || ram1_valid_out) begin
                check(!(ram0_valid_out && ram1_valid_out), "both_valids", {ram0_valid_out, ram1_valid_out}, 0);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", {ram1_valid_out, ram0_valid_out}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(ram1_valid_out == e[8], "beat_bank", int'(ram1_valid_out), int'(e[8]));
                    if (e[8]) begin
                        check(ram1_data_out == e[7:0], "ram1_data", ram1_data_out, e[7:0]);
                        check(ram0_data_out == 8'h00, "ram0_idle_data", ram0_data_out, 0);
                    end else begin
                        check(ram0_data_out == e[7:0], "ram0_data", ram0_data_out, e[7:0]);
                        check(ram1_data_out == 8'h00, "ram1_idle_data", ram1_data_out, 0);
                    end
                    check(cyc == last_start + 2 + beat_k, "beat_cycle", cyc, last_start + 2 + beat_k);
                    beat_k++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d, output int waited);
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        waited = t;
        if (t >= 200) begin
            check(1'b0, "accept_timeout", t, 0);
        end else begin
            exp_q.push_back({mdl_bank, d});
            last_acc = cyc;
            mdl_cnt++;
            if (mdl_cnt == LL) begin
                mdl_cnt  = 0;
                mdl_bank = !mdl_bank;
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_line(input logic [7:0] base, input bit gap);
        int w;
        for (int i = 0; i < LL; i++) begin
            send(base + 8'(i), w);
            if (gap) idle();
        end
        idle();
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < 400) begin
            @(negedge clk);
            t++;
        end
        check(t < 400, name, t, 0);
    endtask

    task automatic check_quiet(input string tag);
        check(start == 1'b0, {tag, "_start"}, start, 0);
        check(!ram0_valid_out && !ram1_valid_out, {tag, "_valids"}, {ram0_valid_out, ram1_valid_out}, 0);
        check(ram0_data_out == 8'h00 && ram1_data_out == 8'h00, {tag, "_data"},
              {ram0_data_out, ram1_data_out}, 0);
        check(busy == 1'b0, {tag, "_busy"}, busy, 0);
        check(in_ready == 1'b1, {tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        int sb, w, stalls_early, rise_cyc;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");

        // One line at full rate on bank 0; start two cycles after the last accept.
        sb = start_cnt;
        send_line(8'h10, 1'b0);
        wait_idle("line1_drain");
        check(start_cnt - sb == 1, "line1_start_count", start_cnt - sb, 1);
        check(start_cycs[sb] == last_acc + 2, "fill_to_start", start_cycs[sb], last_acc + 2);

        // Two back-to-back lines: second on bank 1, 16 cycles between starts.
        sb = start_cnt;
        send_line(8'h00, 1'b0);
        send_line(8'h80, 1'b0);
        wait_idle("two_lines_drain");
        check(start_cnt - sb == 2, "two_lines_start_count", start_cnt - sb, 2);
        if (start_cnt - sb == 2)
            check(start_cycs[sb+1] - start_cycs[sb] == 16, "line_period",
                  start_cycs[sb+1] - start_cycs[sb], 16);

        // Three lines at full rate: stall after 16 samples until bank 0 is released.
        sb = start_cnt;
        stalls_early = 0;
        rise_cyc = 0;
        for (int i = 0; i < 3 * LL; i++) begin
            send(8'h20 + 8'(i), w);
            if (i < 16 && w != 0) stalls_early++;
            if (i == 16) begin
                check(w > 0, "stall_after_16", w, 1);
                rise_cyc = cyc;
            end
        end
        idle();
        check(stalls_early == 0, "no_stall_before_16", stalls_early, 0);
        check(start_cnt > sb, "three_lines_first_start", start_cnt - sb, 1);
        if (start_cnt > sb)
            check(rise_cyc == start_cycs[sb] + 15, "in_ready_rise", rise_cyc, start_cycs[sb] + 15);
        wait_idle("three_lines_drain");
        check(start_cnt - sb == 3, "three_lines_start_count", start_cnt - sb, 3);

        // Gapped input still replays as one contiguous line (beat_cycle covers contiguity).
        sb = start_cnt;
        send_line(8'h50, 1'b1);
        wait_idle("gapped_drain");
        check(start_cnt - sb == 1, "gapped_start_count", start_cnt - sb, 1);

        // Reset during READ of a line on bank 0, then a fresh line from bank 0.
        sb = start_cnt;
        send_line(8'h60, 1'b0);
        w = 0;
        while (start_cnt == sb && w < 100) begin
            @(negedge clk);
            w++;
        end
        check(w < 100, "reset_test_start_seen", w, 0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        mdl_bank = 1'b0;
        mdl_cnt  = 0;
        @(negedge clk);
        check_quiet("mid_reset");
        send_line(8'h70, 1'b0);
        wait_idle("post_reset_drain");

`ifdef GS_FEED_LINE_CNT_EN
        send_line(8'hA0, 1'b0);
        send_line(8'hB0, 1'b0);
        wait_idle("cnt_lines_drain");
        check(line_cnt == 16'd3, "line_cnt_three", line_cnt, 3);
        @(negedge clk);
        force dut.line_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.line_cnt_q;
        send_line(8'hC0, 1'b0);
        wait_idle("cnt_wrap_drain");
        check(line_cnt == 16'd0, "line_cnt_wrap", line_cnt, 0);
`endif

        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

endmodule
